// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encoding, access size codes and timeout for mem_arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        GRANT_IF  = 2'b01,
        GRANT_MEM = 2'b10
    } arb_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [3:0] TIMEOUT = 4'd15;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = addr_lo[0];
            SIZE_WORD: misaligned = |addr_lo;
            default:   misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_gen.sv
// rtl/mem_lane_gen.sv - big-endian byte-lane select and store-data replication
module mem_lane_gen
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  sel,
    output logic [31:0] lane_wdata
);

    always_comb begin
        sel        = 4'b1111;
        lane_wdata = wdata;
        case (size)
            SIZE_BYTE: begin
                sel        = 4'b1000 >> addr_lo;
                lane_wdata = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                sel        = addr_lo[1] ? 4'b0011 : 4'b1100;
                lane_wdata = {2{wdata[15:0]}};
            end
            default: begin
                sel        = 4'b1111;
                lane_wdata = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/MEM arbiter onto one SRAM port; MEM_ARB_BYTE_LANE_EN enables byte lanes
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        bus_err,
    output logic        stall_req,
    output logic        bus_ce,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);

    arb_state_e  state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        last_mem_q, last_mem_d;
    logic        misalign_q, misalign_d;
    logic        bus_ce_q, bus_ce_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        if_ack_q, if_ack_d;
    logic        mem_ack_q, mem_ack_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic        if_pend, mem_pend, grant_if, grant_mem;
    logic        if_mis, mem_mis, done, err, owner_req;
    logic [31:0] done_rdata;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;

`ifdef MEM_ARB_BYTE_LANE_EN
    mem_lane_gen u_lane_gen (
        .size       (mem_size),
        .addr_lo    (mem_addr[1:0]),
        .wdata      (mem_wdata),
        .sel        (lane_sel),
        .lane_wdata (lane_wdata)
    );
`else
    assign lane_sel   = 4'b1111;
    assign lane_wdata = mem_wdata;
`endif

    always_comb begin
        // A requester being acked this cycle still holds req; it must not be regranted.
        if_pend   = if_req & ~if_ack_q;
        mem_pend  = mem_req & ~mem_ack_q;
        grant_if  = if_pend & (last_mem_q | ~mem_pend);
        grant_mem = mem_pend & ~grant_if;
        if_mis    = misaligned(SIZE_WORD, if_addr[1:0]);
        mem_mis   = misaligned(mem_size, mem_addr[1:0]);

        done       = misalign_q | bus_ready | (wait_cnt_q == TIMEOUT);
        err        = misalign_q | ~bus_ready;
        done_rdata = err ? 32'h0 : bus_rdata;
        owner_req  = (state_q == GRANT_MEM) ? mem_req : if_req;

        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        last_mem_d  = last_mem_q;
        misalign_d  = misalign_q;
        bus_ce_d    = bus_ce_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        bus_err_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            IDLE: begin
                wait_cnt_d = 4'd0;
                if (grant_mem) begin
                    state_d     = GRANT_MEM;
                    last_mem_d  = 1'b1;
                    misalign_d  = mem_mis;
                    bus_ce_d    = ~mem_mis;
                    bus_we_d    = mem_we & ~mem_mis;
                    bus_addr_d  = {mem_addr[31:2], 2'b00};
                    bus_sel_d   = lane_sel;
                    bus_wdata_d = lane_wdata;
                end else if (grant_if) begin
                    state_d     = GRANT_IF;
                    last_mem_d  = 1'b0;
                    misalign_d  = if_mis;
                    bus_ce_d    = ~if_mis;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = {if_addr[31:2], 2'b00};
                    bus_sel_d   = 4'b1111;
                    bus_wdata_d = 32'h0;
                end
            end
            GRANT_IF, GRANT_MEM: begin
                if (done) begin
                    state_d  = IDLE;
                    bus_ce_d = 1'b0;
                    bus_we_d = 1'b0;
                    // An abandoned request finishes its bus cycle silently.
                    if (owner_req) begin
                        bus_err_d = err;
                        if (state_q == GRANT_MEM) begin
                            mem_ack_d   = 1'b1;
                            mem_rdata_d = done_rdata;
                        end else begin
                            if_ack_d    = 1'b1;
                            if_rdata_d  = done_rdata;
                        end
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            last_mem_q  <= 1'b0;
            misalign_q  <= 1'b0;
            bus_ce_q    <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_sel_q   <= 4'b0000;
            bus_wdata_q <= 32'h0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            last_mem_q  <= last_mem_d;
            misalign_q  <= misalign_d;
            bus_ce_q    <= bus_ce_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            bus_err_q   <= bus_err_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign stall_req = (if_req | mem_req) & ~(if_ack_q | mem_ack_q);
    assign bus_ce    = bus_ce_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_sel   = bus_sel_q;
    assign bus_wdata = bus_wdata_q;
    assign if_ack    = if_ack_q;
    assign mem_ack   = mem_ack_q;
    assign bus_err   = bus_err_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;

endmodule
